// File: rtl/grf_wb_arbiter.sv
// Round-robin write-back arbiter for the general register file's single write port.
// Define GRF_ARB_TRACE_EN to print each committed write and same-address collisions.
module grf_wb_arbiter #(
    parameter int NREQ  = 3,
    parameter int PTR_W = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              hold,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [5*NREQ-1:0] req_addr,
    input  logic [32*NREQ-1:0] req_data,
    input  logic [32*NREQ-1:0] req_pc,
    output logic [4:0]        grf_waddr,
    output logic [31:0]       grf_wdata,
    output logic [31:0]       grf_wpc,
    input  logic [4:0]        rd_addr1,
    input  logic [4:0]        rd_addr2,
    output logic              busy1,
    output logic              busy2,
    output logic              fwd_valid1,
    output logic              fwd_valid2,
    output logic [31:0]       fwd_data1,
    output logic [31:0]       fwd_data2
);

    logic [4:0]       addr_a [NREQ];
    logic [31:0]      data_a [NREQ];
    logic [31:0]      pc_a   [NREQ];
    logic [NREQ-1:0]  zero_drop;
    logic [NREQ-1:0]  elig;
    logic [NREQ-1:0]  hit1;
    logic [NREQ-1:0]  hit2;
    logic [NREQ-1:0]  gnt_onehot;
    logic             gnt_vld;
    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] cand;

    logic [PTR_W-1:0] ptr_d, ptr_q;
    logic [4:0]       waddr_d, waddr_q;
    logic [31:0]      wdata_d, wdata_q;
    logic [31:0]      wpc_d, wpc_q;

    for (genvar i = 0; i < NREQ; i++) begin : g_req
        assign addr_a[i]    = req_addr[5*i +: 5];
        assign data_a[i]    = req_data[32*i +: 32];
        assign pc_a[i]      = req_pc[32*i +: 32];
        // Writes to x0 are accepted and thrown away without touching arbitration.
        assign zero_drop[i] = req_valid[i] & (addr_a[i] == 5'd0);
        assign elig[i]      = req_valid[i] & (addr_a[i] != 5'd0) & ~hold;
        assign hit1[i]      = req_valid[i] & (addr_a[i] == rd_addr1);
        assign hit2[i]      = req_valid[i] & (addr_a[i] == rd_addr2);
    end

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            cand = (cand == PTR_W'(NREQ - 1)) ? '0 : cand + 1'b1;
            if (!gnt_vld && elig[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        gnt_onehot = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt_onehot[i] = gnt_vld & (gnt_idx == PTR_W'(i));
        end
    end

    assign req_ready = resetn ? (zero_drop | gnt_onehot) : '0;

    always_comb begin
        ptr_d   = ptr_q;
        waddr_d = 5'd0;
        wdata_d = wdata_q;
        wpc_d   = wpc_q;
        if (gnt_vld) begin
            ptr_d   = gnt_idx;
            waddr_d = addr_a[gnt_idx];
            wdata_d = data_a[gnt_idx];
            wpc_d   = pc_a[gnt_idx];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_q   <= PTR_W'(NREQ - 1);
            waddr_q <= 5'd0;
            wdata_q <= 32'd0;
            wpc_q   <= 32'd0;
        end else begin
            ptr_q   <= ptr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            wpc_q   <= wpc_d;
        end
    end

    assign grf_waddr = waddr_q;
    assign grf_wdata = wdata_q;
    assign grf_wpc   = wpc_q;

    // A pending request outranks the output stage: its value is newer than what is about to commit.
    assign busy1      = (rd_addr1 != 5'd0) & (|hit1);
    assign busy2      = (rd_addr2 != 5'd0) & (|hit2);
    assign fwd_valid1 = (rd_addr1 != 5'd0) & (rd_addr1 == waddr_q) & ~busy1;
    assign fwd_valid2 = (rd_addr2 != 5'd0) & (rd_addr2 == waddr_q) & ~busy2;
    assign fwd_data1  = fwd_valid1 ? wdata_q : 32'd0;
    assign fwd_data2  = fwd_valid2 ? wdata_q : 32'd0;

`ifdef GRF_ARB_TRACE_EN
    always @(posedge clk) begin
        if (resetn && waddr_q != 5'd0) begin
            $display("%0t@%h: %0d <= %h", $time, wpc_q, waddr_q, wdata_q);
        end
        if (resetn) begin
            for (int i = 0; i < NREQ; i++) begin
                for (int j = i + 1; j < NREQ; j++) begin
                    if (req_valid[i] && req_valid[j] && addr_a[i] != 5'd0 && addr_a[i] == addr_a[j]) begin
                        $display("%0t warning: requesters %0d and %0d both target r%0d", $time, i, j, addr_a[i]);
                    end
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter: handshake, round-robin order, hazards, hold and async reset.
module tb_grf_wb_arbiter;

    localparam int NREQ = 3;

    logic              clk = 1'b0;
    logic              resetn;
    logic              hold;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [5*NREQ-1:0] req_addr;
    logic [32*NREQ-1:0] req_data;
    logic [32*NREQ-1:0] req_pc;
    logic [4:0]        grf_waddr;
    logic [31:0]       grf_wdata;
    logic [31:0]       grf_wpc;
    logic [4:0]        rd_addr1, rd_addr2;
    logic              busy1, busy2, fwd_valid1, fwd_valid2;
    logic [31:0]       fwd_data1, fwd_data2;

    grf_wb_arbiter #(.NREQ(NREQ), .PTR_W(2)) dut (
        .clk(clk), .resetn(resetn), .hold(hold),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .req_pc(req_pc),
        .grf_waddr(grf_waddr), .grf_wdata(grf_wdata), .grf_wpc(grf_wpc),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .busy1(busy1), .busy2(busy2),
        .fwd_valid1(fwd_valid1), .fwd_valid2(fwd_valid2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    int          ncmp = 0;
    int          nerr = 0;
    logic [31:0] last_d = 32'd0;
    logic [31:0] last_pc = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] a,
                           input logic [31:0] d, input logic [31:0] pc);
        req_valid[i]        = v;
        req_addr[5*i +: 5]  = a;
        req_data[32*i +: 32] = d;
        req_pc[32*i +: 32]  = pc;
    endtask

    // Record the write the output stage must show after the coming edge.
    task automatic expect_write(input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc);
        exp_t e;
        e.a = a; e.d = d; e.pc = pc;
        last_d = d; last_pc = pc;
        sb.push_back(e);
    endtask

    task automatic expect_idle();
        exp_t e;
        e.a = 5'd0; e.d = last_d; e.pc = last_pc;
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        @(negedge clk);
        ncmp++;
        assert (sb.size() != 0) else begin
            nerr++;
            $error("FAIL sb_empty: observed %0d entries expected 1", sb.size());
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("grf_waddr", 32'(grf_waddr), 32'(e.a));
            chk("grf_wdata", grf_wdata, e.d);
            chk("grf_wpc", grf_wpc, e.pc);
        end
    endtask

    task automatic chk_in(input string tag, input logic [NREQ-1:0] rdy,
                          input logic b1, input logic b2);
        #1;
        chk({tag, "_ready"}, 32'(req_ready), 32'(rdy));
        chk({tag, "_busy1"}, 32'(busy1), 32'(b1));
        chk({tag, "_busy2"}, 32'(busy2), 32'(b2));
    endtask

    initial begin
        resetn = 1'b0; hold = 1'b0;
        req_valid = '0; req_addr = '0; req_data = '0; req_pc = '0;
        rd_addr1 = 5'd0; rd_addr2 = 5'd0;

        // Reset: nothing is accepted, output stage cleared.
        set_req(0, 1'b1, 5'd5, 32'h1, 32'h10);
        set_req(1, 1'b1, 5'd0, 32'h2, 32'h20);
        @(negedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_waddr", 32'(grf_waddr), 32'd0);
        chk("rst_wdata", grf_wdata, 32'd0);
        chk("rst_wpc", grf_wpc, 32'd0);
        @(negedge clk);
        req_valid = '0;
        resetn = 1'b1;

        // Idle after reset.
        chk_in("idle0", 3'b000, 1'b0, 1'b0); expect_idle(); tick();
        chk_in("idle1", 3'b000, 1'b0, 1'b0); expect_idle(); tick();

        // All three valid: grants 0,1,2 in consecutive cycles.
        set_req(0, 1'b1, 5'd5, 32'hAAAA_0001, 32'h0000_1000);
        set_req(1, 1'b1, 5'd6, 32'hBBBB_0002, 32'h0000_1004);
        set_req(2, 1'b1, 5'd7, 32'hCCCC_0003, 32'h0000_1008);
        rd_addr1 = 5'd6;
        chk_in("rr0", 3'b001, 1'b1, 1'b0);
        expect_write(5'd5, 32'hAAAA_0001, 32'h0000_1000); tick();
        req_valid[0] = 1'b0;
        chk_in("rr1", 3'b010, 1'b1, 1'b0);
        expect_write(5'd6, 32'hBBBB_0002, 32'h0000_1004); tick();
        req_valid[1] = 1'b0;
        chk_in("rr2", 3'b100, 1'b0, 1'b0);
        expect_write(5'd7, 32'hCCCC_0003, 32'h0000_1008); tick();
        req_valid[2] = 1'b0;
        rd_addr1 = 5'd0;
        chk_in("rr3", 3'b000, 1'b0, 1'b0);
        expect_idle(); tick();

        // Zero-address drop alongside a real grant; pointer lands on 2.
        set_req(1, 1'b1, 5'd0, 32'h1111_1111, 32'h0000_2000);
        set_req(2, 1'b1, 5'd9, 32'hD00D_0009, 32'h0000_2004);
        chk_in("zero", 3'b110, 1'b0, 1'b0);
        expect_write(5'd9, 32'hD00D_0009, 32'h0000_2004); tick();
        req_valid = '0;
        set_req(0, 1'b1, 5'd10, 32'hEEEE_000A, 32'h0000_2008);
        set_req(2, 1'b1, 5'd11, 32'hFFFF_000B, 32'h0000_200C);
        chk_in("ptr2", 3'b001, 1'b0, 1'b0);
        expect_write(5'd10, 32'hEEEE_000A, 32'h0000_2008); tick();
        req_valid[0] = 1'b0;
        chk_in("ptr0", 3'b100, 1'b0, 1'b0);
        expect_write(5'd11, 32'hFFFF_000B, 32'h0000_200C); tick();
        req_valid = '0;

        // Busy while pending, forward once only the output stage holds r3.
        set_req(0, 1'b1, 5'd3, 32'h1234_5678, 32'h0000_3000);
        rd_addr1 = 5'd3;
        chk_in("haz0", 3'b001, 1'b1, 1'b0);
        chk("haz0_fwd", 32'(fwd_valid1), 32'd0);
        expect_write(5'd3, 32'h1234_5678, 32'h0000_3000); tick();
        chk_in("haz1", 3'b001, 1'b1, 1'b0);
        chk("haz1_fwd", 32'(fwd_valid1), 32'd0);
        chk("haz1_fdat", fwd_data1, 32'd0);
        expect_write(5'd3, 32'h1234_5678, 32'h0000_3000); tick();
        req_valid[0] = 1'b0;
        chk_in("haz2", 3'b000, 1'b0, 1'b0);
        chk("haz2_fwd", 32'(fwd_valid1), 32'd1);
        chk("haz2_fdat", fwd_data1, 32'h1234_5678);
        chk("haz2_fwd2", 32'(fwd_valid2), 32'd0);
        expect_idle(); tick();
        #1;
        chk("haz3_fwd", 32'(fwd_valid1), 32'd0);
        rd_addr1 = 5'd0;

        // Async reset mid-burst: output clears without a clock edge.
        set_req(0, 1'b1, 5'd12, 32'h0C0C_000C, 32'h0000_4000);
        set_req(1, 1'b1, 5'd13, 32'h0D0D_000D, 32'h0000_4004);
        set_req(2, 1'b1, 5'd14, 32'h0E0E_000E, 32'h0000_4008);
        chk_in("burst0", 3'b010, 1'b0, 1'b0);
        expect_write(5'd13, 32'h0D0D_000D, 32'h0000_4004); tick();
        req_valid[1] = 1'b0;
        chk_in("burst1", 3'b100, 1'b0, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_waddr", 32'(grf_waddr), 32'd0);
        chk("arst_wdata", grf_wdata, 32'd0);
        chk("arst_ready", 32'(req_ready), 32'd0);
        sb.delete();
        last_d = 32'd0; last_pc = 32'd0;
        @(posedge clk);
        @(negedge clk);
        chk("arst_hold_waddr", 32'(grf_waddr), 32'd0);
        resetn = 1'b1;

        // Hold after reset, with a zero-address drop still accepted.
        hold = 1'b1;
        set_req(1, 1'b1, 5'd13, 32'h0D0D_000D, 32'h0000_4004);
        set_req(2, 1'b1, 5'd0, 32'h0, 32'h0000_400C);
        rd_addr1 = 5'd12; rd_addr2 = 5'd13;
        chk_in("hold0", 3'b100, 1'b1, 1'b1);
        expect_idle(); tick();
        req_valid[2] = 1'b0;
        chk_in("hold1", 3'b000, 1'b1, 1'b1);
        expect_idle(); tick();
        hold = 1'b0;
        chk_in("rel0", 3'b001, 1'b1, 1'b1);
        expect_write(5'd12, 32'h0C0C_000C, 32'h0000_4000); tick();
        req_valid[0] = 1'b0;
        chk_in("rel1", 3'b010, 1'b0, 1'b1);
        expect_write(5'd13, 32'h0D0D_000D, 32'h0000_4004); tick();
        req_valid = '0;
        chk_in("rel2", 3'b000, 1'b0, 1'b0);
        expect_idle(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/grf_wb_arbiter.md
Name: grf_wb_arbiter

Overview:
- Shares the single write port of the general register file between NREQ write-back sources (main pipeline WB, multiply/divide unit, load-miss return).
- Uses round-robin arbitration with valid/ready handshakes.
- A registered output stage drives the register file write address, data and debug PC.
- Read-side hazard outputs let issue logic stall or forward around pending writes.

Parameters:
- NREQ, 3, number of write-back requesters (2..8); index 0 wins the first arbitration after reset.
- PTR_W, 2, width of round-robin pointer; must satisfy 2^PTR_W >= NREQ.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- hold  in  1  1 = grant nothing this cycle (exception/debug freeze).
- req_valid  in  NREQ  per-requester write request.
- req_ready  out  NREQ  per-requester accept; transfer when valid&ready at clk edge.
- req_addr  in  5*NREQ  destination register, requester i at bits [5i+4:5i].
- req_data  in  32*NREQ  write data, requester i at [32i+31:32i].
- req_pc  in  32*NREQ  PC of the producing instruction.
- grf_waddr  out  5  register file write address; 0 = no write.
- grf_wdata  out  32  register file write data.
- grf_wpc  out  32  debug PC accompanying the write.
- rd_addr1  in  5  issue-stage read address 1.
- rd_addr2  in  5  issue-stage read address 2.
- busy1  out  1  rd_addr1 has a pending, not-forwardable write.
- busy2  out  1  rd_addr2 has a pending, not-forwardable write.
- fwd_valid1  out  1  rd_addr1 data available from output stage.
- fwd_valid2  out  1  rd_addr2 data available from output stage.
- fwd_data1  out  32  forwarded data for rd_addr1.
- fwd_data2  out  32  forwarded data for rd_addr2.

Behaviour:
- Reset (resetn=0, asynchronous): grf_waddr=0, grf_wdata=0, grf_wpc=0, RR pointer=NREQ-1 (port 0 searched first). All req_ready=0 while resetn=0. Reset mid-transfer discards the output stage and the in-flight grant; requesters re-present after reset.
- Zero-address requests: req_valid[i]&addr==0 → req_ready[i]=1 combinationally, regardless of hold. The request is dropped, consumes no grant and leaves the pointer unchanged. Several zero-address requests may be dropped in the same cycle.
- Grant: only when hold=0. Search valid nonzero-address requesters starting at pointer+1 mod NREQ; the first found gets req_ready=1.
  - At most one nonzero grant per cycle.
  - Pointer ← granted index at the clock edge.
  - req_ready is combinational from req_valid, hold and the pointer; it never depends on req_ready.
- Output stage: loads granted addr/data/pc at the edge, visible the next cycle (latency 1). The register file commits it at the following edge.
  - If no grant, grf_waddr←0; grf_wdata and grf_wpc are don't-care but are held at their previous values.
  - The output stage never stalls; the register file always accepts.
- Ordering: writes to the same register from different requesters commit in grant order. Requesters ensure program order themselves; the arbiter does not reorder within a requester.
- Hazard, evaluated per read port k:
  - m_out = (rd_addrk!=0) & (rd_addrk==grf_waddr).
  - m_req = (rd_addrk!=0) & any valid requester with req_addr==rd_addrk.
  - busyk = m_req.
  - fwd_validk = m_out & ~m_req.
  - fwd_datak = grf_wdata when fwd_validk, else 0.
  - rd_addr 0 never produces busy or fwd.
- hold=1: the output stage drains to grf_waddr=0 on the next edge; the pointer is unchanged; pending requests stay valid and keep asserting busy.

Optional Feature:
- Macro: GRF_ARB_TRACE_EN.
- Defined: at each rising edge with grf_waddr!=0 and resetn=1, print "$time@pc: $addr <= data" via $display, plus a $display warning if two requesters were valid with the same nonzero address in one cycle.
- Undefined: no simulation output; RTL behaviour is identical.

Test Plan:
- Reset release, req_valid=3'b000 → grf_waddr=0 every cycle; busy1/2=0; req_ready=0 while resetn=0.
- All three valid, addrs 5/6/7, data A/B/C, hold=0 → grants 0,1,2 on consecutive cycles; grf_waddr=5,6,7 with data A,B,C, each one cycle after its grant.
- Requester 1 valid with addr 0 and requester 2 valid with addr 9, same cycle → req_ready=3'b110; next cycle grf_waddr=9; pointer=2.
- Requester 0 continuously valid with addr 3, rd_addr1=3 → busy1=1 and fwd_valid1=0 while pending. After requester 0 drops valid, the cycle with grf_waddr=3 gives fwd_valid1=1 and fwd_data1=written value.
- hold=1 for 2 cycles with requesters 0 and 1 valid → req_ready=0, grf_waddr=0. On hold release, requester 0 is granted first after reset; busy follows the pending addresses throughout.
- resetn pulsed low mid-burst, asynchronous to clk → grf_waddr=0 immediately without a clock edge; after release, arbitration restarts from port 0.
